mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that shares the single byte-wide RAM port between the instruction fetcher and the LoadStoreBuffer. It arbitrates between the two requesters and sequences each granted 1/2/4-byte access into byte-serial RAM cycles. It assembles read data little-endian and returns a one-cycle done pulse. It sits between the fetch/LSB units and the top-level RAM pins, downstream of what the Dispatcher feeds into the LSB.

## Interface
- `ADDR_WIDTH`, 32: address width of all address ports.
- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_n_in`  in  1  reset; asynchronous, active-low.
- `rdy_in`  in  1  global ready; low freezes all state.
- `rob_flush_in`  in  1  misprediction flush; aborts reads, never writes.
- `if_req_in`  in  1  fetch request (level, held until done).
- `if_addr_in`  in  ADDR_WIDTH  fetch address; always 4 bytes.
- `if_done_out`  out  1  one-cycle pulse: `if_data_out` valid.
- `if_data_out`  out  32  fetched word.
- `lsb_req_in`  in  1  LSB request (level, held until done).
- `lsb_we_in`  in  1  1 = store, 0 = load.
- `lsb_size_in`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- `lsb_addr_in`  in  ADDR_WIDTH  access base address.
- `lsb_wdata_in`  in  32  store data; low bytes are used first.
- `lsb_done_out`  out  1  one-cycle pulse: access complete.
- `lsb_rdata_out`  out  32  load data, zero-extended. Sign extension is done by the LSB.
- `mem_din_in`  in  8  RAM read byte. It returns one cycle after its address.
- `mem_dout_out`  out  8  RAM write byte.
- `mem_a_out`  out  ADDR_WIDTH  RAM address.
- `mem_wr_out`  out  1  RAM write enable; gated with `rdy_in`.

## Operation
- FSM states: IDLE, READ, WRITE.
- Byte count n: 1, 2 or 4, from size. Fetch is always n = 4.
- **Grant (IDLE only):**
  - If exactly one requester is pending, it is granted.
  - If both are pending, round-robin against a `last_grant` register. `last_grant` resets to LSB, so IF wins the first tie.
  - A requester whose done is high in the current cycle is masked from grant.
  - Requesters must drop `req` in the cycle after their done pulse.
- On grant: latch owner, address, n, wdata and we; clear byte counter and buffer. Go to READ (IF, or LSB load) or WRITE (LSB store).
- **READ:**
  - Drive `mem_a_out` = base + i for i = 0..n-1 on consecutive cycles.
  - Capture `mem_din_in` into buffer byte i one cycle after address i.
  - After the last capture: pulse the owner's done with assembled data, return to IDLE.
  - Unused upper bytes of the data output read 0.
- **WRITE:**
  - Drive `mem_a_out` = base + i, `mem_dout_out` = wdata[8i+7:8i] and `mem_wr_out` = 1 for i = 0..n-1.
  - Then pulse `lsb_done_out` and return to IDLE.
- **Flush:**
  - When `rob_flush_in` is high at an edge while in READ: go to IDLE with no done pulse.
  - In that same IDLE cycle, no grant is made from requests sampled with flush high.
  - WRITE ignores flush and completes (stores are already committed).
- **rdy_in low:** FSM, counter, buffer and registered outputs hold; `mem_wr_out` = 0. Resuming re-presents the held address, so read data stays correct.
- Address arithmetic is modulo 2^ADDR_WIDTH; base + i wraps.
- Reset (asynchronous): state IDLE, `mem_a_out` = 0, `mem_dout_out` = 0, `mem_wr_out` = 0, both done = 0, both data outputs = 0, counter = 0.

## Timing
- All outputs are registered, except `mem_wr_out`, which is the register ANDed with `rdy_in`.
- Request seen in IDLE at cycle T:
  - Read: addresses on `mem_a_out` in T+1..T+n; bytes arrive T+2..T+n+1; done is high in T+n+2. A fetch completes in T+6.
  - Write: bytes driven T+1..T+n; done is high in T+n+1. A word store completes in T+5.
- The done cycle is an IDLE cycle, so the other requester can be granted there (next access starts at done+1).
- Every cycle with `rdy_in` low adds exactly one cycle to the latency.

## Structure
- Add to `header.v`:
  - state encodings `MC_IDLE`, `MC_READ`, `MC_WRITE`;
  - owner constants `MC_OWNER_IF`, `MC_OWNER_LSB`;
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
- Reuse the existing `TRUE`/`FALSE` macros.
- Single module `mem_ctrl`; no sub-module. The round-robin choice is a few gates.

## Test plan
- **IF only:** fetch 0x00001000 with RAM bytes 0x13,0x05,0x10,0x00 -> `mem_a_out` steps 0x1000..0x1003; `if_done_out` in T+6 with `if_data_out` = 0x00100513.
- **LSB store:** half store 0x0000BEEF to 0x20 -> writes 0xEF@0x20, then 0xBE@0x21; `lsb_done_out` in T+3; no third write.
- **Contention:** IF and LSB both pending from reset -> IF granted first; LSB is granted in the IF done cycle; IF's re-request then waits for LSB done.
- **Flush:** flush during the 3rd byte of a fetch -> IDLE next cycle, no `if_done_out`. Flush during a word store -> all 4 writes occur and `lsb_done_out` pulses.
- **Stall and wrap:** byte load at 0xFFFFFFFF with `rdy_in` low for 2 cycles mid-read -> done delayed by 2, data correct. Word load at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- **Async reset:** assert `rst_n_in` low mid-write -> `mem_wr_out` drops to 0 immediately, all outputs reach reset values, FSM is in IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory controller.
//   mc_state_e    - controller FSM states (idle, byte-serial read, byte-serial write)
//   mc_owner_e    - which requester currently owns the RAM port
//   SIZE_*        - LSB access size encodings
//   size_to_bytes - maps a size encoding to its byte count (illegal 3 -> word)
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  typedef enum logic {
    MC_OWNER_IF  = 1'b0,
    MC_OWNER_LSB = 1'b1
  } mc_owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the
// LoadStoreBuffer. Arbitrates round-robin on ties, then sequences each 1/2/4
// byte access into consecutive byte cycles, assembling read data little-endian.
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   rdy_in                  global ready; low freezes all state
//   rob_flush_in            aborts an in-flight read (writes always complete)
//   if_req_in/if_addr_in    fetch request (always 4 bytes)
//   if_done_out/if_data_out one-cycle completion pulse and fetched word
//   lsb_req_in/lsb_we_in/lsb_size_in/lsb_addr_in/lsb_wdata_in  LSB request
//   lsb_done_out/lsb_rdata_out one-cycle completion pulse and zero-extended load data
//   mem_din_in/mem_dout_out/mem_a_out/mem_wr_out  RAM pins (read data 1 cycle late)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  rob_flush_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  lsb_req_in,
  input  logic                  lsb_we_in,
  input  logic [1:0]            lsb_size_in,
  input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
  input  logic [31:0]           lsb_wdata_in,
  output logic                  lsb_done_out,
  output logic [31:0]           lsb_rdata_out,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out
);

  mc_state_e             state_q, state_d;
  mc_owner_e             owner_q, owner_d;
  mc_owner_e             last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;

  logic                  if_pend, lsb_pend, grant_if, grant_lsb;
  logic [2:0]            next_idx;
  logic [1:0]            cap_idx;
  logic [31:0]           buf_ins;
  logic [ADDR_WIDTH-1:0] grant_addr;

  always_comb begin
    // A requester whose done pulse is visible this cycle has not yet dropped req.
    if_pend   = if_req_in && !if_done_q;
    lsb_pend  = lsb_req_in && !lsb_done_q;
    grant_if  = if_pend && (!lsb_pend || (last_grant_q == MC_OWNER_LSB));
    grant_lsb = lsb_pend && !grant_if;
    grant_addr = grant_if ? if_addr_in : lsb_addr_in;

    next_idx = cnt_q + 3'd1;
    // Byte returning now belongs to the address issued one cycle earlier.
    cap_idx  = cnt_q[1:0] - 2'd1;
    buf_ins  = buf_q;
    buf_ins[{cap_idx, 3'b000} +: 8] = mem_din_in;

    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    if_done_d    = 1'b0;
    if_data_d    = if_data_q;
    lsb_done_d   = 1'b0;
    lsb_rdata_d  = lsb_rdata_q;

    case (state_q)
      MC_IDLE: begin
        if (!rob_flush_in && (grant_if || grant_lsb)) begin
          owner_d      = grant_if ? MC_OWNER_IF : MC_OWNER_LSB;
          last_grant_d = grant_if ? MC_OWNER_IF : MC_OWNER_LSB;
          base_d       = grant_addr;
          n_d          = grant_if ? 3'd4 : size_to_bytes(lsb_size_in);
          cnt_d        = 3'd0;
          buf_d        = 32'd0;
          wdata_d      = lsb_wdata_in;
          mem_a_d      = grant_addr;
          if (grant_lsb && lsb_we_in) begin
            state_d    = MC_WRITE;
            mem_dout_d = lsb_wdata_in[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d    = MC_READ;
          end
        end
      end
      MC_READ: begin
        if (rob_flush_in) begin
          state_d = MC_IDLE;
        end else begin
          if (cnt_q != 3'd0) buf_d = buf_ins;
          if (cnt_q == n_q) begin
            state_d = MC_IDLE;
            if (owner_q == MC_OWNER_IF) begin
              if_done_d = 1'b1;
              if_data_d = buf_ins;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_ins;
            end
          end else begin
            cnt_d = next_idx;
            if (next_idx < n_q) mem_a_d = base_q + ADDR_WIDTH'(next_idx);
          end
        end
      end
      MC_WRITE: begin
        if (next_idx < n_q) begin
          cnt_d      = next_idx;
          mem_a_d    = base_q + ADDR_WIDTH'(next_idx);
          mem_dout_d = wdata_q[{next_idx[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end else begin
          lsb_done_d = 1'b1;
          state_d    = MC_IDLE;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // Whole controller freezes while rdy_in is low, so a resumed read re-presents
  // the same address and counter position.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= MC_IDLE;
      owner_q      <= MC_OWNER_IF;
      last_grant_q <= MC_OWNER_LSB;
      base_q       <= '0;
      n_q          <= 3'd0;
      cnt_q        <= 3'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      if_data_q    <= 32'd0;
      lsb_done_q   <= 1'b0;
      lsb_rdata_q  <= 32'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      if_data_q    <= if_data_d;
      lsb_done_q   <= lsb_done_d;
      lsb_rdata_q  <= lsb_rdata_d;
    end
  end

  assign mem_a_out     = mem_a_q;
  assign mem_dout_out  = mem_dout_q;
  assign mem_wr_out    = mem_wr_q & rdy_in;
  assign if_done_out   = if_done_q;
  assign if_data_out   = if_data_q;
  assign lsb_done_out  = lsb_done_q;
  assign lsb_rdata_out = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl. A behavioural RAM returns the byte
// for each address one cycle later; unlisted addresses read addr[7:0]^8'hA5.
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        rob_flush_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        lsb_req_in;
  logic        lsb_we_in;
  logic [1:0]  lsb_size_in;
  logic [31:0] lsb_addr_in;
  logic [31:0] lsb_wdata_in;
  logic        lsb_done_out;
  logic [31:0] lsb_rdata_out;
  logic [7:0]  mem_din_in;
  logic [7:0]  mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_init [logic [31:0]];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .rob_flush_in  (rob_flush_in),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_done_out   (if_done_out),
    .if_data_out   (if_data_out),
    .lsb_req_in    (lsb_req_in),
    .lsb_we_in     (lsb_we_in),
    .lsb_size_in   (lsb_size_in),
    .lsb_addr_in   (lsb_addr_in),
    .lsb_wdata_in  (lsb_wdata_in),
    .lsb_done_out  (lsb_done_out),
    .lsb_rdata_out (lsb_rdata_out),
    .mem_din_in    (mem_din_in),
    .mem_dout_out  (mem_dout_out),
    .mem_a_out     (mem_a_out),
    .mem_wr_out    (mem_wr_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_init.exists(a)) return ram_init[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  // RAM read data appears one cycle after its address.
  always @(posedge clk_in) mem_din_in <= ram_rd(mem_a_out);

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    ram_init[32'h1000] = 8'h13;
    ram_init[32'h1001] = 8'h05;
    ram_init[32'h1002] = 8'h10;
    ram_init[32'h1003] = 8'h00;

    rst_n_in = 1'b0; rdy_in = 1'b1; rob_flush_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = 32'd0;
    lsb_req_in = 1'b0; lsb_we_in = 1'b0; lsb_size_in = 2'd0;
    lsb_addr_in = 32'd0; lsb_wdata_in = 32'd0;

    tick(2);
    chk("rst_mem_a", mem_a_out, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr_out}, 32'd0);
    chk("rst_dout", {24'd0, mem_dout_out}, 32'd0);
    chk("rst_if_done", {31'd0, if_done_out}, 32'd0);
    chk("rst_lsb_done", {31'd0, lsb_done_out}, 32'd0);
    chk("rst_if_data", if_data_out, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata_out, 32'd0);
    rst_n_in = 1'b1;

    // Contention from reset: IF wins first tie, LSB word store granted in IF done cycle.
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    lsb_req_in = 1'b1; lsb_we_in = 1'b1; lsb_size_in = 2'd2;
    lsb_addr_in = 32'h40; lsb_wdata_in = 32'hDDCCBBAA;
    tick(1);
    chk("tie_if_a0", mem_a_out, 32'h1000);
    chk("tie_if_nowr", {31'd0, mem_wr_out}, 32'd0);
    tick(1); chk("fetch_a1", mem_a_out, 32'h1001);
    tick(1); chk("fetch_a2", mem_a_out, 32'h1002);
    tick(1); chk("fetch_a3", mem_a_out, 32'h1003);
    tick(1); chk("fetch_not_early", {31'd0, if_done_out}, 32'd0);
    tick(1);
    chk("fetch_done", {31'd0, if_done_out}, 32'd1);
    chk("fetch_data", if_data_out, 32'h00100513);
    chk("fetch_no_lsb_done", {31'd0, lsb_done_out}, 32'd0);
    tick(1);
    if_req_in = 1'b0;
    chk("st_a0", mem_a_out, 32'h40);
    chk("st_d0", {24'd0, mem_dout_out}, 32'hAA);
    chk("st_wr0", {31'd0, mem_wr_out}, 32'd1);
    tick(1);
    if_req_in = 1'b1; if_addr_in = 32'h2000;
    chk("st_a1", mem_a_out, 32'h41);
    chk("st_d1", {24'd0, mem_dout_out}, 32'hBB);
    tick(1); chk("st_d2", {24'd0, mem_dout_out}, 32'hCC);
    tick(1);
    chk("st_a3", mem_a_out, 32'h43);
    chk("st_d3", {24'd0, mem_dout_out}, 32'hDD);
    tick(1);
    chk("st_done", {31'd0, lsb_done_out}, 32'd1);
    chk("st_done_nowr", {31'd0, mem_wr_out}, 32'd0);
    chk("if_waits", {31'd0, if_done_out}, 32'd0);
    tick(1);
    lsb_req_in = 1'b0;
    chk("if2_a0", mem_a_out, 32'h2000);
    tick(5);
    chk("if2_done", {31'd0, if_done_out}, 32'd1);
    chk("if2_data", if_data_out, 32'hA6A7A4A5);
    tick(1);
    if_req_in = 1'b0;
    chk("if2_pulse_one", {31'd0, if_done_out}, 32'd0);

    // Half store 0xBEEF to 0x20.
    lsb_req_in = 1'b1; lsb_we_in = 1'b1; lsb_size_in = 2'd1;
    lsb_addr_in = 32'h20; lsb_wdata_in = 32'h0000BEEF;
    tick(1);
    chk("hs_a0", mem_a_out, 32'h20);
    chk("hs_d0", {24'd0, mem_dout_out}, 32'hEF);
    chk("hs_wr0", {31'd0, mem_wr_out}, 32'd1);
    tick(1);
    chk("hs_a1", mem_a_out, 32'h21);
    chk("hs_d1", {24'd0, mem_dout_out}, 32'hBE);
    chk("hs_wr1", {31'd0, mem_wr_out}, 32'd1);
    tick(1);
    chk("hs_done", {31'd0, lsb_done_out}, 32'd1);
    chk("hs_no_third_wr", {31'd0, mem_wr_out}, 32'd0);
    tick(1);
    chk("hs_idle_nowr", {31'd0, mem_wr_out}, 32'd0);
    chk("hs_pulse_one", {31'd0, lsb_done_out}, 32'd0);

    // Word store with flush mid-way: all four writes still happen.
    lsb_req_in = 1'b1; lsb_we_in = 1'b1; lsb_size_in = 2'd2;
    lsb_addr_in = 32'h80; lsb_wdata_in = 32'h44332211;
    tick(1); chk("fs_d0", {24'd0, mem_dout_out}, 32'h11);
    tick(1);
    rob_flush_in = 1'b1;
    chk("fs_a1", mem_a_out, 32'h81);
    tick(1);
    rob_flush_in = 1'b0;
    chk("fs_d2", {24'd0, mem_dout_out}, 32'h33);
    chk("fs_wr2", {31'd0, mem_wr_out}, 32'd1);
    tick(1);
    chk("fs_a3", mem_a_out, 32'h83);
    chk("fs_d3", {24'd0, mem_dout_out}, 32'h44);
    tick(1);
    chk("fs_done", {31'd0, lsb_done_out}, 32'd1);
    tick(1);
    lsb_req_in = 1'b0;

    // Fetch flushed during its third byte: no done, controller idle next cycle.
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    tick(3);
    chk("ff_a2", mem_a_out, 32'h1002);
    rob_flush_in = 1'b1; if_req_in = 1'b0;
    tick(1);
    rob_flush_in = 1'b0;
    chk("ff_no_done0", {31'd0, if_done_out}, 32'd0);
    // Byte load at 0xFFFFFFFF, granted right away, then stalled two cycles.
    lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_size_in = 2'd0;
    lsb_addr_in = 32'hFFFFFFFF;
    tick(1);
    chk("ff_idle_grant", mem_a_out, 32'hFFFFFFFF);
    chk("ff_no_done1", {31'd0, if_done_out}, 32'd0);
    tick(1);
    rdy_in = 1'b0;
    tick(1);
    chk("stall_hold_a", mem_a_out, 32'hFFFFFFFF);
    chk("stall_no_done0", {31'd0, lsb_done_out}, 32'd0);
    tick(1);
    rdy_in = 1'b1;
    chk("stall_no_done1", {31'd0, lsb_done_out}, 32'd0);
    tick(1);
    chk("stall_done", {31'd0, lsb_done_out}, 32'd1);
    chk("stall_data", lsb_rdata_out, 32'h0000005A);
    chk("ff_no_done2", {31'd0, if_done_out}, 32'd0);
    tick(1);
    lsb_req_in = 1'b0;
    tick(1);

    // Word load wrapping across the top of the address space.
    lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_size_in = 2'd2;
    lsb_addr_in = 32'hFFFFFFFE;
    tick(1); chk("wrap_a0", mem_a_out, 32'hFFFFFFFE);
    tick(1); chk("wrap_a1", mem_a_out, 32'hFFFFFFFF);
    tick(1); chk("wrap_a2", mem_a_out, 32'h00000000);
    tick(1); chk("wrap_a3", mem_a_out, 32'h00000001);
    tick(2);
    chk("wrap_done", {31'd0, lsb_done_out}, 32'd1);
    chk("wrap_data", lsb_rdata_out, 32'hA4A55A5B);
    tick(1);
    lsb_req_in = 1'b0;
    tick(1);

    // Asynchronous reset in the middle of a word store.
    lsb_req_in = 1'b1; lsb_we_in = 1'b1; lsb_size_in = 2'd2;
    lsb_addr_in = 32'h100; lsb_wdata_in = 32'h87654321;
    tick(2);
    chk("ar_wr_before", {31'd0, mem_wr_out}, 32'd1);
    chk("ar_a_before", mem_a_out, 32'h101);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("ar_wr_drop", {31'd0, mem_wr_out}, 32'd0);
    chk("ar_mem_a", mem_a_out, 32'd0);
    chk("ar_dout", {24'd0, mem_dout_out}, 32'd0);
    chk("ar_lsb_rdata", lsb_rdata_out, 32'd0);
    chk("ar_if_data", if_data_out, 32'd0);
    chk("ar_lsb_done", {31'd0, lsb_done_out}, 32'd0);
    lsb_req_in = 1'b0;
    tick(2);
    rst_n_in = 1'b1;
    tick(1);
    chk("ar_idle_nowr", {31'd0, mem_wr_out}, 32'd0);
    lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_size_in = 2'd0;
    lsb_addr_in = 32'h1000;
    tick(1);
    chk("ar_regrant_a", mem_a_out, 32'h1000);
    chk("ar_regrant_nowr", {31'd0, mem_wr_out}, 32'd0);
    tick(2);
    chk("ar_load_done", {31'd0, lsb_done_out}, 32'd1);
    chk("ar_load_data", lsb_rdata_out, 32'h00000013);
    tick(1);
    lsb_req_in = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
